sync_fifo_wr_arb: RTL

//  Round-robin write arbiter sharing one sync_fifo write port among NUM_REQ producers.

---
 rtl/sync_fifo_pkg.sv | 24 ++
 rtl/fifo_rr_pick.sv | 41 ++++
 rtl/sync_fifo_wr_arb.sv | 116 +++++++++++
 3 files changed

// File: rtl/sync_fifo_pkg.sv
// Purpose: shared types and helpers for the sync_fifo write-side arbiter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: arbiter FSM state encoding and a constant-foldable clog2 used to
// size ports and counters from parameters.
package sync_fifo_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  // Smallest r with 2**r >= value; returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_rr_pick.sv
// Purpose: rotating-priority picker; first set request at or after ptr_i (mod NUM_REQ).
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the pick is consumed.
//
// Ports:
//   req_i       in   NUM_REQ  request vector
//   ptr_i       in   ID_W     index with highest priority this cycle
//   pick_oh_o   out  NUM_REQ  one-hot winner (all zero when req_i is zero)
//   pick_idx_o  out  ID_W     index of the winner (zero when req_i is zero)
module fifo_rr_pick
  import sync_fifo_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] pick_oh_o,
  output logic [ID_W-1:0]    pick_idx_o
);

  logic [ID_W-1:0] idx;
  logic            found;

  // Walk the ring starting at ptr_i; the first hit wins and masks the rest.
  always_comb begin
    pick_oh_o  = '0;
    pick_idx_o = '0;
    found      = 1'b0;
    idx        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ID_W'((int'(ptr_i) + k) % NUM_REQ);
      if (!found && req_i[idx]) begin
        found          = 1'b1;
        pick_oh_o[idx] = 1'b1;
        pick_idx_o     = idx;
      end
    end
  end

endmodule

// File: rtl/sync_fifo_wr_arb.sv
// Purpose: round-robin arbiter sharing one sync_fifo write port among NUM_REQ producers.
// Latency: 1 cycle request-to-grant; within a grant, words pass combinationally to the FIFO.
// Backpressure: fifo_full_i freezes the grant (no write, no ready, burst count held).
//
// Ports:
//   clk_i            in   1               system clock, rising edge
//   rst_ni           in   1               asynchronous active-low reset
//   req_valid_i      in   NUM_REQ         per-producer word available
//   req_data_i       in   NUM_REQ*DATA_W  producer i data at [i*DATA_W +: DATA_W]
//   req_ready_o      out  NUM_REQ         word of producer i accepted this cycle
//   fifo_full_i      in   1               FIFO cannot take a word
//   fifo_wr_en_o     out  1               FIFO write strobe
//   fifo_wr_data_o   out  DATA_W          FIFO write data
//   grant_id_o       out  clog2(NUM_REQ)  current / most recent granted producer
//   busy_o           out  1               high while a grant is held
module sync_fifo_wr_arb
  import sync_fifo_pkg::*;
#(
  parameter  int NUM_REQ   = 4,
  parameter  int DATA_W    = 16,
  parameter  int BURST_LEN = 8,
  localparam int ID_W      = clog2(NUM_REQ),
  localparam int CNT_W     = clog2(BURST_LEN + 1)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  input  logic                      fifo_full_i,
  output logic                      fifo_wr_en_o,
  output logic [DATA_W-1:0]         fifo_wr_data_o,
  output logic [ID_W-1:0]           grant_id_o,
  output logic                      busy_o
);

  state_e             state_q, state_d;
  logic [ID_W-1:0]    grant_q, grant_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [NUM_REQ-1:0] pick_oh;
  logic [ID_W-1:0]    pick_idx;
  logic               granted;
  logic               acc;
  logic               burst_done;
  logic [DATA_W-1:0]  words [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_words
    assign words[g] = req_data_i[g*DATA_W +: DATA_W];
  end

  fifo_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req_i      (req_valid_i),
    .ptr_i      (rr_ptr_q),
    .pick_oh_o  (pick_oh),
    .pick_idx_o (pick_idx)
  );

  // Outputs depend only on registered state and current inputs, so the async
  // reset forcing state_q to IDLE drops every strobe immediately.
  assign granted    = (state_q == GRANT);
  assign acc        = granted & req_valid_i[grant_q] & ~fifo_full_i;
  assign burst_done = acc & (cnt_q == CNT_W'(BURST_LEN - 1));

  assign fifo_wr_en_o   = acc;
  assign req_ready_o    = acc ? (NUM_REQ'(1) << grant_q) : '0;
  assign fifo_wr_data_o = granted ? words[grant_q] : '0;
  assign grant_id_o     = grant_q;
  assign busy_o         = granted;

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (|pick_oh) begin
          grant_d = pick_idx;
          cnt_d   = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (acc) begin
          cnt_d = cnt_q + 1'b1;
        end
        // A full-burst release and a valid-drop release cannot both be live
        // (acc needs valid), and both go to IDLE with the same pointer update.
        if (burst_done || !req_valid_i[grant_q]) begin
          state_d  = IDLE;
          rr_ptr_d = (grant_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule
